// File: rtl/depacketizer.sv
// Flit depacketizer: pops one flit from an upstream FIFO, splits it into head, body
// and tail fields and holds them behind a valid/ready handshake.
// Optional tail-mark check enabled by defining DEPACKETIZER_TAIL_CHECK_EN.
module depacketizer #(
  parameter int unsigned        FLIT_W    = 48,
  parameter int unsigned        FIELD_W   = 16,
  parameter logic [FIELD_W-1:0] TAIL_MARK = 16'hFFFF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               fifo_empty,
  input  logic [FLIT_W-1:0]  flit_in,
  output logic               read_enable,
  output logic [FIELD_W-1:0] HF,
  output logic [FIELD_W-1:0] BF,
  output logic [FIELD_W-1:0] TF,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [15:0]        flit_count,
  output logic               err_flag,
  output logic [7:0]         err_count
);

  typedef enum logic [1:0] {StIdle, StWait, StHold} state_e;

  state_e             state_q, state_d;
  logic [FIELD_W-1:0] hf_q, hf_d, bf_q, bf_d, tf_q, tf_d;
  logic               out_valid_q, out_valid_d;
  logic [15:0]        flit_count_q, flit_count_d;
  logic               capture;
  logic               transfer;

  // Next-state and pop request; a pop is only issued when the output slot frees up.
  always_comb begin
    state_d     = state_q;
    read_enable = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (!fifo_empty) begin
          read_enable = 1'b1;
          state_d     = StWait;
        end
      end
      StWait: state_d = StHold;
      StHold: begin
        if (out_ready) begin
          if (!fifo_empty) begin
            read_enable = 1'b1;
            state_d     = StWait;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
    // No pop may reach the FIFO while the block is held in reset.
    if (reset) begin
      read_enable = 1'b0;
    end
  end

  assign capture  = (state_q == StWait);
  assign transfer = (state_q == StHold) && out_ready;

  // Field capture, valid flag and transfer counter next-state.
  always_comb begin
    hf_d         = hf_q;
    bf_d         = bf_q;
    tf_d         = tf_q;
    out_valid_d  = out_valid_q;
    flit_count_d = flit_count_q;
    if (capture) begin
      hf_d        = flit_in[3*FIELD_W-1:2*FIELD_W];
      bf_d        = flit_in[2*FIELD_W-1:FIELD_W];
      tf_d        = flit_in[FIELD_W-1:0];
      out_valid_d = 1'b1;
    end else if (transfer) begin
      out_valid_d = 1'b0;
    end
    if (transfer) begin
      flit_count_d = flit_count_q + 16'd1;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      hf_q         <= '0;
      bf_q         <= '0;
      tf_q         <= '0;
      out_valid_q  <= 1'b0;
      flit_count_q <= '0;
    end else begin
      state_q      <= state_d;
      hf_q         <= hf_d;
      bf_q         <= bf_d;
      tf_q         <= tf_d;
      out_valid_q  <= out_valid_d;
      flit_count_q <= flit_count_d;
    end
  end

  assign HF         = hf_q;
  assign BF         = bf_q;
  assign TF         = tf_q;
  assign out_valid  = out_valid_q;
  assign flit_count = flit_count_q;

`ifdef DEPACKETIZER_TAIL_CHECK_EN
  logic       err_flag_q, err_flag_d;
  logic [7:0] err_count_q, err_count_d;

  // Flag a bad tail for one cycle after capture; the flit is still delivered.
  always_comb begin
    err_flag_d  = 1'b0;
    err_count_d = err_count_q;
    if (capture && (flit_in[FIELD_W-1:0] != TAIL_MARK)) begin
      err_flag_d = 1'b1;
      if (err_count_q != 8'hFF) begin
        err_count_d = err_count_q + 8'd1;
      end
    end
  end

  // Error flag and saturating error counter registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
    end else begin
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
    end
  end

  assign err_flag  = err_flag_q;
  assign err_count = err_count_q;
`else
  // Tail check compiled out; the mark parameter is only kept for interface symmetry.
  logic unused_tail_mark;
  assign unused_tail_mark = ^TAIL_MARK;
  assign err_flag         = 1'b0;
  assign err_count        = 8'h00;
`endif

endmodule

// File: tb/tb_depacketizer.sv
// Randomized self-checking bench for depacketizer with a queue-based reference model.
// Honours DEPACKETIZER_TAIL_CHECK_EN for the error outputs.
module tb_depacketizer;

  localparam logic [15:0] TailMark = 16'hFFFF;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [47:0] flit_in = '0;
  logic        read_enable;
  logic [15:0] hf, bf, tf;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] flit_count;
  logic        err_flag;
  logic [7:0]  err_count;

  depacketizer dut (
    .clk        (clk),
    .reset      (reset),
    .fifo_empty (fifo_empty),
    .flit_in    (flit_in),
    .read_enable(read_enable),
    .HF         (hf),
    .BF         (bf),
    .TF         (tf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .flit_count (flit_count),
    .err_flag   (err_flag),
    .err_count  (err_count)
  );

  always #5 clk = ~clk;

  // Environment FIFO contents and the model's queue of flits popped but not yet delivered.
  logic [47:0] fifo_q[$];
  logic [47:0] exp_q[$];
  bit          re_h1, re_h2;     // read_enable one and two cycles ago
  bit          ov_prev, rdy_prev;
  logic [15:0] wait_tail;
  logic [15:0] cnt_m;
  logic [7:0]  errc_m;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    re_h1    = 1'b0;
    re_h2    = 1'b0;
    ov_prev  = 1'b0;
    rdy_prev = 1'b0;
    cnt_m    = '0;
    errc_m   = '0;
  endtask

  task automatic check_reset_outputs();
    check("rst_hf", hf, 0);
    check("rst_bf", bf, 0);
    check("rst_tf", tf, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_flit_count", flit_count, 0);
    check("rst_err_flag", err_flag, 0);
    check("rst_err_count", err_count, 0);
    check("rst_read_enable", read_enable, 0);
  endtask

  // One clock cycle: drive inputs on the falling edge, then predict and compare.
  task automatic step(input bit push, input logic [47:0] data, input bit rdy);
    logic [63:0] rnd;
    logic [15:0] prev_tail;
    bit          ov_exp, re_exp, err_exp;
    @(negedge clk);
    prev_tail = wait_tail;
    if (re_h1 && fifo_q.size() > 0) begin
      flit_in   = fifo_q.pop_front();
      exp_q.push_back(flit_in);
      wait_tail = flit_in[15:0];
    end else begin
      rnd     = {$urandom(), $urandom()};
      flit_in = rnd[47:0];
    end
    if (push) fifo_q.push_back(data);
    out_ready  = rdy;
    fifo_empty = (fifo_q.size() == 0);
    #1;
    // Data popped at cycle t appears at t+2 and stays until accepted.
    ov_exp = re_h2 || (ov_prev && !rdy_prev);
    check("out_valid", out_valid, ov_exp);
    if (ov_exp && exp_q.size() > 0) begin
      check("HF", hf, exp_q[0][47:32]);
      check("BF", bf, exp_q[0][31:16]);
      check("TF", tf, exp_q[0][15:0]);
    end
    // Pop only when data exists, none is in flight and the output slot is free or freeing.
    re_exp = !fifo_empty && !re_h1 && (!ov_exp || rdy);
    check("read_enable", read_enable, re_exp);
    check("flit_count", flit_count, cnt_m);
`ifdef DEPACKETIZER_TAIL_CHECK_EN
    err_exp = re_h2 && (prev_tail != TailMark);
    if (err_exp && errc_m != 8'hFF) errc_m++;
`else
    err_exp = 1'b0;
`endif
    check("err_flag", err_flag, err_exp);
    check("err_count", err_count, errc_m);
    if (ov_exp && rdy) begin
      if (exp_q.size() > 0) void'(exp_q.pop_front());
      cnt_m++;
    end
    re_h2    = re_h1;
    re_h1    = read_enable;
    ov_prev  = ov_exp;
    rdy_prev = rdy;
  endtask

  task automatic idle_cycles(input int n, input bit rdy);
    for (int i = 0; i < n; i++) step(1'b0, '0, rdy);
  endtask

  // Asynchronous reset mid-cycle; the FIFO is shown empty while reset is high.
  task automatic pulse_reset();
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs();
    fifo_empty = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_clear();
  endtask

  initial begin
    logic [47:0] d;
    model_clear();
    wait_tail = TailMark;
    #3;
    check_reset_outputs();
    fifo_empty = 1'b0;
    #1;
    check("rst_read_enable_nonempty", read_enable, 0);
    fifo_empty = 1'b1;
    @(negedge clk);
    reset = 1'b0;

    // Single flit through an always-ready sink.
    step(1'b1, 48'h1111_2222_FFFF, 1'b1);
    idle_cycles(6, 1'b1);

    // Four queued flits stream at one per two cycles.
    for (int i = 0; i < 4; i++) fifo_q.push_back({16'hA000 + 16'(i), 16'hB000 + 16'(i), TailMark});
    idle_cycles(12, 1'b1);

    // Long stall with a second flit waiting, then release.
    step(1'b1, 48'h3333_4444_FFFF, 1'b0);
    step(1'b1, 48'h5555_6666_FFFF, 1'b0);
    idle_cycles(12, 1'b0);
    idle_cycles(6, 1'b1);

    // Bad tail is flagged (when checking is built in) and still delivered.
    step(1'b1, 48'h7777_8888_1234, 1'b1);
    idle_cycles(5, 1'b1);

    // Reset while holding a flit, with another still queued upstream.
    step(1'b1, 48'h9999_AAAA_FFFF, 1'b0);
    step(1'b1, 48'hBBBB_CCCC_FFFF, 1'b0);
    idle_cycles(4, 1'b0);
    pulse_reset();

    // Counter wrap: preload all-ones, deliver the queued flit.
    force dut.flit_count_q = 16'hFFFF;
    #1;
    release dut.flit_count_q;
    cnt_m = 16'hFFFF;
    idle_cycles(6, 1'b1);

    // Randomized traffic and backpressure.
    for (int i = 0; i < 500; i++) begin
      d[47:16] = $urandom();
      d[15:0]  = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 16'hFFFE)) : TailMark;
      step($urandom_range(0, 9) < 4, d, $urandom_range(0, 9) < 6);
    end
    idle_cycles(40, 1'b1);
    check("drained_fifo", fifo_q.size(), 0);
    check("drained_model", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
